sha256_padder: RTL and testbench
================================

# sha256_padder

Upstream feeder for `sha256_compressor`. It accepts a message as a byte stream and applies FIPS 180-4 padding: a 0x80 terminator, zero fill, and the 64-bit big-endian bit length. It emits complete 512-bit blocks over a valid/ready handshake, with first/last flags. The downstream controller uses these flags to select the IV or the chained hash as `initial_hash` and to know when to pulse `start`.

## Interface
- `MAX_LEN_BITS`, 64: width of the message bit-length counter. Fixed by the standard; must be 64.
- `clk` in 1: sole clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` is valid.
- `in_data` in 8: message byte, in stream order.
- `in_last` in 1: with `in_valid`, marks the final byte of the message.
- `in_ready` out 1: padder accepts a byte this cycle.
- `block_valid` out 1: `block_data` holds a complete padded block.
- `block_ready` in 1: downstream takes the block.
- `block_data` out 512: block, big-endian; byte 0 sits at [511:504].
- `block_first` out 1: block is the first of its message.
- `block_last` out 1: block is the final block of its message.
- `msg_blocks` out 16: only with `SHA256_PADDER_STATS_EN`; see Configuration.

## Operation
- States: ACCUM, EMIT, EMIT_PAD.
- **ACCUM**
  - `in_ready=1`. Each accepted byte is written at byte index `n` (0..63); then `n+1`, and `bitlen += 8`.
- **Non-last byte brings n to 64** → EMIT with `block_last=0`.
- **Last byte accepted, k = bytes in the block after the write (1..64):**
  - `k ≤ 55`: byte k = 0x80, bytes k+1..55 = 0, bytes 56..63 = bitlen (including this byte) → EMIT, `block_last=1`.
  - `56 ≤ k ≤ 63`: byte k = 0x80, bytes above it = 0 → EMIT, `block_last=0`, with a pad block pending (no terminator needed).
  - `k = 64` → EMIT, `block_last=0`, with a pad block pending (terminator 0x80 at byte 0).
- **EMIT**
  - Holds `block_valid=1` and the data stable until `block_ready`.
  - On handshake: if a pad block is pending → EMIT_PAD; otherwise → ACCUM with `n=0`. If the block was last, `bitlen=0` and `first` is set.
- **EMIT_PAD**
  - Block = optional 0x80 at byte 0, zeros, then bitlen at bytes 56..63. `block_last=1`.
  - On handshake → ACCUM; clear `n` and `bitlen`, set `first`.
- `block_first` is 1 for the first block emitted after reset or after a last block; 0 otherwise, including for a pad block.
- Zero-length messages are not supported; `in_last` always accompanies a data byte.
- Unused buffer bytes must read 0 when emitted; the buffer is cleared on each return to ACCUM.
- **Reset mid-message:** the partial block and the length are discarded, with no block emitted. The next byte starts a new message with `block_first=1`.

## Timing
- While `rst=1`: `in_ready=0`, `block_valid=0`, `block_data=0`, `block_first=0`, `block_last=0`, `msg_blocks=0`. The state is ACCUM, `n=0`, `bitlen=0`, and `first=1`.
- `in_ready=1` from the first cycle after `rst` deasserts, while in ACCUM (combinational from the state, gated by `rst`).
- The 64th byte or last byte is accepted at cycle t; `block_valid=1` at t+1.
- The block handshake occurs at cycle t. A pad block is valid at t+1. Otherwise `in_ready=1` at t+1.
- `in_ready=0` throughout EMIT and EMIT_PAD; `in_valid` is ignored there.
- Outputs are registered apart from `in_ready`. With `block_valid=1` and `block_ready=0`, all block outputs hold stable.
- Throughput: 64 byte cycles plus at least 1 emit cycle per block.

## Configuration
- `SHA256_PADDER_STATS_EN`
  - Defined: `msg_blocks` counts blocks handshaken for the current message, 1-based, saturating at 0xFFFF. It is valid alongside `block_valid`, and resets to 0 after the last block's handshake and on `rst`.
  - Undefined: the port and the counter are absent.

## Structure
- `sha256_pkg`:
  - state enum `pad_state_t`
  - `SHA256_BLOCK_BITS=512`, `SHA256_BLOCK_BYTES=64`, `SHA256_LEN_BYTES=8`, `SHA256_PAD_LIMIT=55`
  - `SHA256_PAD_BYTE=8'h80`
  - This is shared with the compressor and the hash controller.
- One sub-module: `sha256_pad_insert`. It is combinational. Given the buffer, k, the bitlen, and the mode {final, spill, pad_only}, it returns the 512-bit padded block. The top module holds the FSM, buffer, and counters.

## Test plan
- **"abc"** (0x61,0x62,0x63, last on 0x63) → one block, `block_data = 512'h61626380_00…00_00000018`, first=1, last=1.
- **55 bytes** of 0x00 → one block: bytes 0..54 = 0x00, byte 55 = 0x80, length = 0x1B8, last=1.
- **56 bytes** → two blocks.
  - Block 1: byte 56 = 0x80, last=0, first=1.
  - Block 2: all zero except length = 0x1C0, first=0, last=1.
- **64 bytes** → two blocks. Block 2 = 0x80 at byte 0, zeros, length = 0x200. With `STATS_EN`, `msg_blocks` reads 1 then 2.
- **Backpressure**: hold `block_ready=0` for 10 cycles → `block_valid` and data are stable, and `in_ready=0`. The handshake is followed by `in_ready=1` the next cycle. Two back-to-back "abc" messages → each gives first=1, last=1.
- **Reset after 30 bytes**, then "abc" → no block emitted for the aborted message; the next block equals the "abc" vector exactly.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions used by the padder, the compressor and the hash controller.
package sha256_pkg;

  localparam int SHA256_BLOCK_BITS  = 512;
  localparam int SHA256_BLOCK_BYTES = 64;
  localparam int SHA256_LEN_BYTES   = 8;
  localparam int SHA256_PAD_LIMIT   = 55;

  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ACCUM,
    EMIT,
    EMIT_PAD
  } pad_state_t;

  // How the block buffer is turned into an outgoing block:
  // NONE     - buffer as is (full block, no padding inside it)
  // FINAL    - terminator at byte k, zero fill, bit length in the tail
  // SPILL    - terminator at byte k (if k < 64), zero fill, length follows in a pad block
  // PAD_ONLY - extra block: optional terminator at byte 0, zeros, bit length in the tail
  typedef enum logic [1:0] {
    MODE_NONE,
    MODE_FINAL,
    MODE_SPILL,
    MODE_PAD_ONLY
  } pad_mode_t;

endpackage

// File: rtl/sha256_pad_insert.sv
// Combinational padding insertion: builds a 512-bit big-endian block from the
// message buffer, the byte count k, the message bit length and the padding mode.
// In PAD_ONLY mode, k = 64 asks for the 0x80 terminator at byte 0.
module sha256_pad_insert
  import sha256_pkg::*;
(
  input  logic [SHA256_BLOCK_BITS-1:0] buf_in,
  input  logic [6:0]                   k,
  input  logic [63:0]                  bitlen,
  input  pad_mode_t                    mode,
  output logic [SHA256_BLOCK_BITS-1:0] block
);

  localparam int LEN_START = SHA256_BLOCK_BYTES - SHA256_LEN_BYTES;

  // Decide each output byte independently: message byte, terminator, length byte or zero
  always_comb begin
    block = '0;
    for (int i = 0; i < SHA256_BLOCK_BYTES; i++) begin
      unique case (mode)
        MODE_NONE: begin
          block[8*(63-i) +: 8] = buf_in[8*(63-i) +: 8];
        end
        MODE_FINAL: begin
          if (7'(i) < k)
            block[8*(63-i) +: 8] = buf_in[8*(63-i) +: 8];
          else if (7'(i) == k)
            block[8*(63-i) +: 8] = SHA256_PAD_BYTE;
          else if (i >= LEN_START)
            block[8*(63-i) +: 8] = bitlen[8*(7-(i%8)) +: 8];
        end
        MODE_SPILL: begin
          if (7'(i) < k)
            block[8*(63-i) +: 8] = buf_in[8*(63-i) +: 8];
          else if (7'(i) == k)
            block[8*(63-i) +: 8] = SHA256_PAD_BYTE;
        end
        MODE_PAD_ONLY: begin
          if ((i == 0) && (k == 7'(SHA256_BLOCK_BYTES)))
            block[8*(63-i) +: 8] = SHA256_PAD_BYTE;
          else if (i >= LEN_START)
            block[8*(63-i) +: 8] = bitlen[8*(7-(i%8)) +: 8];
        end
        default: begin
          block[8*(63-i) +: 8] = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects a byte stream into 64-byte blocks, applies the
// 0x80 terminator, zero fill and 64-bit bit length, and hands out complete blocks
// with first/last flags over a valid/ready handshake.
// Optional feature macro: SHA256_PADDER_STATS_EN adds the msg_blocks block counter.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int MAX_LEN_BITS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         block_valid,
  input  logic                         block_ready,
  output logic [SHA256_BLOCK_BITS-1:0] block_data,
  output logic                         block_first,
  output logic                         block_last
`ifdef SHA256_PADDER_STATS_EN
  ,
  output logic [15:0]                  msg_blocks
`endif
);

  pad_state_t                   state;
  pad_state_t                   state_next;
  logic [SHA256_BLOCK_BITS-1:0] buffer;
  logic [SHA256_BLOCK_BITS-1:0] buf_wr;
  logic [SHA256_BLOCK_BITS-1:0] padded;
  logic [5:0]                   n;
  logic [6:0]                   k_after;
  logic [8:0]                   byte_sel;
  logic [MAX_LEN_BITS-1:0]      bitlen;
  logic [MAX_LEN_BITS-1:0]      bitlen_inc;
  logic                         first;
  logic                         pad_pending;
  logic                         pad_term;
  logic                         accept;
  logic                         handshake;
  logic                         load_block;
  logic                         last_c;
  logic                         pad_c;
  logic                         term_c;
  pad_mode_t                    mode;
  logic [6:0]                   ins_k;
  logic [MAX_LEN_BITS-1:0]      ins_len;

  assign in_ready   = (state == ACCUM) && !rst;
  assign accept     = in_ready && in_valid;
  assign handshake  = block_valid && block_ready;
  assign k_after    = {1'b0, n} + 7'd1;
  assign bitlen_inc = bitlen + MAX_LEN_BITS'(8);
  assign byte_sel   = {6'd63 - n, 3'b000};

  // Buffer contents with the incoming byte already written at index n
  always_comb begin
    buf_wr = buffer;
    buf_wr[byte_sel +: 8] = in_data;
  end

  sha256_pad_insert u_pad_insert (
    .buf_in (buf_wr),
    .k      (ins_k),
    .bitlen (ins_len),
    .mode   (mode),
    .block  (padded)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  // Next state, padding mode and the control for loading a new outgoing block
  always_comb begin
    state_next = state;
    mode       = MODE_NONE;
    ins_k      = k_after;
    ins_len    = bitlen_inc;
    load_block = 1'b0;
    last_c     = 1'b0;
    pad_c      = 1'b0;
    term_c     = 1'b0;
    unique case (state)
      ACCUM: begin
        if (accept) begin
          if (in_last) begin
            load_block = 1'b1;
            state_next = EMIT;
            if (k_after <= 7'(SHA256_PAD_LIMIT)) begin
              mode   = MODE_FINAL;
              last_c = 1'b1;
            end else if (k_after < 7'(SHA256_BLOCK_BYTES)) begin
              mode  = MODE_SPILL;
              pad_c = 1'b1;
            end else begin
              mode   = MODE_NONE;
              pad_c  = 1'b1;
              term_c = 1'b1;
            end
          end else if (k_after == 7'(SHA256_BLOCK_BYTES)) begin
            load_block = 1'b1;
            state_next = EMIT;
          end
        end
      end
      EMIT: begin
        if (handshake) begin
          if (pad_pending) begin
            state_next = EMIT_PAD;
            load_block = 1'b1;
            mode       = MODE_PAD_ONLY;
            ins_k      = pad_term ? 7'(SHA256_BLOCK_BYTES) : 7'd0;
            ins_len    = bitlen;
            last_c     = 1'b1;
          end else begin
            state_next = ACCUM;
          end
        end
      end
      EMIT_PAD: begin
        if (handshake) state_next = ACCUM;
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  // Byte collection, length counting and the registered block outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer      <= '0;
      n           <= '0;
      bitlen      <= '0;
      first       <= 1'b1;
      pad_pending <= 1'b0;
      pad_term    <= 1'b0;
      block_valid <= 1'b0;
      block_data  <= '0;
      block_first <= 1'b0;
      block_last  <= 1'b0;
    end else begin
      if (accept) begin
        bitlen <= bitlen_inc;
        if (load_block) begin
          buffer <= '0;
          n      <= '0;
        end else begin
          buffer <= buf_wr;
          n      <= n + 6'd1;
        end
      end
      if (load_block) begin
        block_data  <= padded;
        block_valid <= 1'b1;
        block_last  <= last_c;
        block_first <= (state == ACCUM) ? first : 1'b0;
        pad_pending <= pad_c;
        pad_term    <= term_c;
        if (state == ACCUM) first <= 1'b0;
      end else if (handshake) begin
        block_valid <= 1'b0;
        block_data  <= '0;
        block_first <= 1'b0;
        block_last  <= 1'b0;
        pad_pending <= 1'b0;
        pad_term    <= 1'b0;
      end
      if (handshake && block_last) begin
        first  <= 1'b1;
        bitlen <= '0;
      end
    end
  end

`ifdef SHA256_PADDER_STATS_EN
  // Per-message block index, 1-based while a block is presented, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_blocks <= '0;
    end else if (load_block) begin
      if (msg_blocks != 16'hFFFF) msg_blocks <= msg_blocks + 16'd1;
    end else if (handshake && block_last) begin
      msg_blocks <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: a reference padding model pushes the
// expected blocks to a scoreboard queue, and a monitor pops and compares them
// as the DUT hands blocks out.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_data;
  logic         block_first;
  logic         block_last;
`ifdef SHA256_PADDER_STATS_EN
  logic [15:0]  msg_blocks;
`endif

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
    logic [15:0]  idx;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] msg_bytes [0:255];
  logic [7:0] pad_bytes [0:255];
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         ready_mode   = 0;

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_data  (block_data),
    .block_first (block_first),
    .block_last  (block_last)
`ifdef SHA256_PADDER_STATS_EN
    ,
    .msg_blocks  (msg_blocks)
`endif
  );

  // Downstream ready: 0 = always ready, 1 = stalled, 2 = random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       block_ready = 1'b1;
      1:       block_ready = 1'b0;
      default: block_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference padding: whole padded message built byte by byte, then split into blocks
  task automatic buildExpected(input int len);
    int          nblk;
    logic [63:0] bits;
    exp_t        e;
    nblk = (len + 8) / 64 + 1;
    for (int i = 0; i < nblk * 64; i++) pad_bytes[i] = 8'h00;
    for (int i = 0; i < len; i++) pad_bytes[i] = msg_bytes[i];
    pad_bytes[len] = 8'h80;
    bits = 64'(len) * 64'd8;
    for (int j = 0; j < 8; j++) pad_bytes[nblk*64-1-j] = bits[8*j +: 8];
    for (int b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = pad_bytes[b*64+j];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      e.idx   = 16'(b + 1);
      sb.push_back(e);
    end
  endtask

  // Drive bytes one at a time, each held until in_ready accepts it
  task automatic driveBytes(input int len, input bit with_last);
    int wait_cnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = msg_bytes[i];
      in_last  = with_last && (i == len - 1);
      wait_cnt = 0;
      @(negedge clk);
      while (!in_ready && wait_cnt < 1000) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!in_ready) checkOutput("accept_timeout", 512'(in_ready), 512'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (with_last && (i == len - 1)) begin
        @(negedge clk);
        checkOutput("valid_latency", 512'(block_valid), 512'd1);
        checkOutput("in_ready_emit", 512'(in_ready), 512'd0);
      end
    end
  endtask

  task automatic applyStimulus(input int len);
    buildExpected(len);
    driveBytes(len, 1'b1);
  endtask

  task automatic waitDrain();
    int cnt = 0;
    while (sb.size() != 0 && cnt < 3000) begin
      @(posedge clk);
      cnt++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 512'(sb.size()), 512'd0);
      sb.delete();
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_in_ready", 512'(in_ready), 512'd0);
    checkOutput("rst_block_valid", 512'(block_valid), 512'd0);
    checkOutput("rst_block_data", block_data, 512'd0);
    checkOutput("rst_block_first", 512'(block_first), 512'd0);
    checkOutput("rst_block_last", 512'(block_last), 512'd0);
`ifdef SHA256_PADDER_STATS_EN
    checkOutput("rst_msg_blocks", 512'(msg_blocks), 512'd0);
`endif
  endtask

  // Scoreboard monitor: each block that will be handshaken at the next edge is compared
  always @(negedge clk) begin
    if (!rst && block_valid && block_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_block", 512'(block_valid), 512'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("block_data", block_data, mon_e.data);
        checkOutput("block_first", 512'(block_first), 512'(mon_e.first));
        checkOutput("block_last", 512'(block_last), 512'(mon_e.last));
`ifdef SHA256_PADDER_STATS_EN
        checkOutput("msg_blocks", 512'(msg_blocks), 512'(mon_e.idx));
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_rst", 512'(in_ready), 512'd1);

    // "abc"
    msg_bytes[0] = 8'h61; msg_bytes[1] = 8'h62; msg_bytes[2] = 8'h63;
    applyStimulus(3);
    waitDrain();

    // 55 zero bytes: terminator and length fit in one block
    for (int i = 0; i < 55; i++) msg_bytes[i] = 8'h00;
    applyStimulus(55);
    waitDrain();

    // 56, 63 and 64 bytes: length spills into a pad block
    for (int i = 0; i < 64; i++) msg_bytes[i] = 8'(i + 1);
    applyStimulus(56);
    waitDrain();
    applyStimulus(63);
    waitDrain();
    applyStimulus(64);
    waitDrain();

    // Single-byte message
    msg_bytes[0] = 8'hA5;
    applyStimulus(1);
    waitDrain();

    // Backpressure: block held for 10 cycles, stray input ignored
    ready_mode = 1;
    msg_bytes[0] = 8'h61; msg_bytes[1] = 8'h62; msg_bytes[2] = 8'h63;
    applyStimulus(3);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checkOutput("stall_valid", 512'(block_valid), 512'd1);
      checkOutput("stall_in_ready", 512'(in_ready), 512'd0);
      if (sb.size() > 0) checkOutput("stall_data", block_data, sb[0].data);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    ready_mode = 0;
    waitDrain();
    @(negedge clk);
    checkOutput("in_ready_after_hs", 512'(in_ready), 512'd1);
    checkOutput("valid_after_hs", 512'(block_valid), 512'd0);

    // Two back-to-back "abc" messages
    applyStimulus(3);
    applyStimulus(3);
    waitDrain();

    // Multi-block random message under random backpressure
    ready_mode = 2;
    for (int i = 0; i < 130; i++) msg_bytes[i] = 8'($urandom_range(0, 255));
    applyStimulus(130);
    waitDrain();
    ready_mode = 0;

    // Reset after 30 bytes, then "abc"
    for (int i = 0; i < 30; i++) msg_bytes[i] = 8'($urandom_range(0, 255));
    driveBytes(30, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    msg_bytes[0] = 8'h61; msg_bytes[1] = 8'h62; msg_bytes[2] = 8'h63;
    applyStimulus(3);
    waitDrain();

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
